// File: rtl/pia8255_port_if.sv
// rtl/pia8255_port_if.sv - CPU-side bus of the 8255-style parallel port
// One access per cycle with cs=1; dout is combinational from addr and state.
interface pia8255_port_if;
    logic       cs;
    logic       rnw;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, output rnw, output addr, output din, input dout);
    modport slave  (input cs, input rnw, input addr, input din, output dout);
endinterface

// File: rtl/pia8255_port.sv
// rtl/pia8255_port.sv - 8255-style PIA: three 8-bit ports, mode 0 plus group-A mode 1
// Port B mode is fixed at 0; group-A mode 1 handshake lives on PC3..PC7.
module pia8255_port #(
    parameter logic [7:0] RESET_CTRL = 8'h8A,
    parameter bit         MODE1_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    pia8255_port_if.slave    bus,
    input  logic [7:0]       pa_in,
    input  logic [7:0]       pb_in,
    input  logic [7:0]       pc_in,
    output logic [7:0]       pa_out,
    output logic [7:0]       pb_out,
    output logic [7:0]       pc_out,
    output logic [7:0]       pa_dir,
    output logic [7:0]       pb_dir,
    output logic [7:0]       pc_dir,
    output logic             intr_a
);
    logic [7:0] ctrl;
    logic [7:0] pa_lat, pb_lat, pc_lat, pa_cap;
    logic       ibf, inte_a, intr_q, obf_n, stb_q, ack_q;

    logic mode1, m1_in, m1_out;
    assign mode1  = MODE1_EN && (ctrl[6:5] == 2'b01);
    assign m1_in  = mode1 && ctrl[4];
    assign m1_out = mode1 && !ctrl[4];

    logic wr, rd, wr_pa, wr_pb, wr_pc, wr_mode, wr_bsr, rd_pa;
    assign wr      = bus.cs && !bus.rnw;
    assign rd      = bus.cs && bus.rnw;
    assign wr_pa   = wr && (bus.addr == 2'b00);
    assign wr_pb   = wr && (bus.addr == 2'b01);
    assign wr_pc   = wr && (bus.addr == 2'b10);
    assign wr_mode = wr && (bus.addr == 2'b11) && bus.din[7];
    assign wr_bsr  = wr && (bus.addr == 2'b11) && !bus.din[7];
    assign rd_pa   = rd && (bus.addr == 2'b00);

    logic stb_fall, ack_fall, ack_rise;
    assign stb_fall = stb_q && !pc_in[4];
    assign ack_fall = ack_q && !pc_in[6];
    assign ack_rise = !ack_q && pc_in[6];

    // Input-mode INTR is a pure function of state so it drops the moment STB_n is sampled low.
    assign intr_a = m1_in  ? (ibf && inte_a && stb_q) :
                    m1_out ? intr_q : 1'b0;

    assign pa_dir = {8{~ctrl[4]}};
    assign pb_dir = {8{~ctrl[1]}};
    assign pa_out = pa_lat;
    assign pb_out = pb_lat;

    always_comb begin
        pc_dir = {{4{~ctrl[3]}}, {4{~ctrl[0]}}};
        pc_out = pc_lat;
        if (m1_in) begin
            pc_dir[3] = 1'b1;
            pc_dir[5] = 1'b1;
            pc_dir[4] = 1'b0;
            pc_out[3] = intr_a;
            pc_out[5] = ibf;
        end else if (m1_out) begin
            pc_dir[3] = 1'b1;
            pc_dir[5] = 1'b1;
            pc_dir[7] = 1'b1;
            pc_dir[6] = 1'b0;
            pc_out[3] = intr_a;
            pc_out[7] = obf_n;
        end
    end

    logic [7:0] pa_rd, pb_rd, pc_rd;
    assign pa_rd = m1_in ? pa_cap : ((pa_dir & pa_lat) | (~pa_dir & pa_in));
    assign pb_rd = (pb_dir & pb_lat) | (~pb_dir & pb_in);

    always_comb begin
        pc_rd = (pc_dir & pc_lat) | (~pc_dir & pc_in);
        if (m1_in) begin
            pc_rd[3] = intr_a;
            pc_rd[4] = inte_a;
            pc_rd[5] = ibf;
        end else if (m1_out) begin
            pc_rd[3] = intr_a;
            pc_rd[6] = inte_a;
            pc_rd[7] = obf_n;
        end
    end

    always_comb begin
        case (bus.addr)
            2'b00:   bus.dout = pa_rd;
            2'b01:   bus.dout = pb_rd;
            2'b10:   bus.dout = pc_rd;
            default: bus.dout = ctrl | 8'h80;
        endcase
    end

    // Later assignments win: handshake events, then bus writes, then mode-set on top.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= RESET_CTRL;
            pa_lat <= 8'h00;
            pb_lat <= 8'h00;
            pc_lat <= 8'h00;
            pa_cap <= 8'h00;
            ibf    <= 1'b0;
            inte_a <= 1'b0;
            intr_q <= 1'b0;
            obf_n  <= 1'b1;
            stb_q  <= 1'b1;
            ack_q  <= 1'b1;
        end else begin
            stb_q <= pc_in[4];
            ack_q <= pc_in[6];
            if (m1_in) begin
                if (stb_fall) begin
                    pa_cap <= pa_in;
                    ibf    <= 1'b1;
                end else if (rd_pa) begin
                    ibf <= 1'b0;
                end
            end
            if (m1_out) begin
                if (ack_fall)
                    obf_n <= 1'b1;
                if (ack_rise && inte_a)
                    intr_q <= 1'b1;
            end
            if (wr_pa) begin
                pa_lat <= bus.din;
                if (m1_out) begin
                    obf_n  <= 1'b0;
                    intr_q <= 1'b0;
                end
            end
            if (wr_pb)
                pb_lat <= bus.din;
            if (wr_pc)
                pc_lat <= bus.din;
            if (wr_bsr) begin
                if (m1_in && bus.din[3:1] == 3'd4)
                    inte_a <= bus.din[0];
                else if (m1_out && bus.din[3:1] == 3'd6)
                    inte_a <= bus.din[0];
                else
                    pc_lat[bus.din[3:1]] <= bus.din[0];
            end
            if (wr_mode) begin
                ctrl   <= bus.din;
                pa_lat <= 8'h00;
                pb_lat <= 8'h00;
                pc_lat <= 8'h00;
                pa_cap <= 8'h00;
                ibf    <= 1'b0;
                inte_a <= 1'b0;
                intr_q <= 1'b0;
                obf_n  <= 1'b1;
            end
        end
    end
endmodule
